// File: rtl/hazard_unit.sv
// Hazard resolver for the 5-stage ARM pipeline: stall, flush and forward
// controls, with E/M/W register tracking and saturating perf counters.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       WA3D,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             BranchTakenE,
  input  logic             PCWrPendingF,
  input  logic             PCSrcW,
  input  logic             ClrCnt,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] BrFlushCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       ra1e_q, ra2e_q, wa3e_q;
  logic [3:0]       wa3m_q, wa3w_q;
  logic [3:0]       ra1e_d, ra2e_d, wa3e_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic             ldr_stall;

  // r15 reads the PC path, so it is never a forwarding candidate
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic       wr_m,
    input logic [3:0] wa_m,
    input logic       wr_w,
    input logic [3:0] wa_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != 4'hF) begin
      if (wr_m && ra == wa_m) begin
        sel = 2'b10;
      end else if (wr_w && ra == wa_w) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  assign ldr_stall = ~reset & MemtoRegE
                   & ((RA1D == wa3e_q) | (RA2D == wa3e_q));

  always_comb begin
    StallF    = ~reset & (ldr_stall | PCWrPendingF);
    StallD    = ldr_stall;
    FlushD    = reset | PCWrPendingF | PCSrcW | BranchTakenE;
    FlushE    = reset | ldr_stall | BranchTakenE;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!reset) begin
      ForwardAE = fwd_sel(ra1e_q, RegWriteM, wa3m_q,
                          RegWriteW, wa3w_q);
      ForwardBE = fwd_sel(ra2e_q, RegWriteM, wa3m_q,
                          RegWriteW, wa3w_q);
    end
  end

  always_comb begin
    ra1e_d = RA1D;
    ra2e_d = RA2D;
    wa3e_d = WA3D;
    if (FlushE) begin
      ra1e_d = 4'h0;
      ra2e_d = 4'h0;
      wa3e_d = 4'h0;
    end
  end

  // Clear beats a same-cycle increment; both counters stick at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    br_cnt_d    = br_cnt_q;
    if (reset || ClrCnt) begin
      stall_cnt_d = '0;
      br_cnt_d    = '0;
    end else begin
      if (StallF && stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (BranchTakenE && br_cnt_q != CNT_MAX) begin
        br_cnt_d = br_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ra1e_q      <= 4'h0;
      ra2e_q      <= 4'h0;
      wa3e_q      <= 4'h0;
      wa3m_q      <= 4'h0;
      wa3w_q      <= 4'h0;
      stall_cnt_q <= '0;
      br_cnt_q    <= '0;
    end else begin
      ra1e_q      <= ra1e_d;
      ra2e_q      <= ra2e_d;
      wa3e_q      <= wa3e_d;
      wa3m_q      <= wa3e_q;
      wa3w_q      <= wa3m_q;
      stall_cnt_q <= stall_cnt_d;
      br_cnt_q    <= br_cnt_d;
    end
  end

  assign StallCnt   = stall_cnt_q;
  assign BrFlushCnt = br_cnt_q;

endmodule
